// File: rtl/tl_pkg.sv
// tl_pkg: light state codes, fault codes, lamp bit positions and decode helpers
// shared by the traffic light controller side and the lamp monitor.
package tl_pkg;
    typedef logic [2:0] state_t;
    typedef logic [2:0] fault_t;

    localparam state_t ST_RR      = 3'd0;
    localparam state_t ST_GG      = 3'd1;
    localparam state_t ST_YY      = 3'd2;
    localparam state_t ST_RG      = 3'd3;
    localparam state_t ST_RY      = 3'd4;
    localparam state_t ST_GR      = 3'd5;
    localparam state_t ST_YR      = 3'd6;
    localparam state_t ST_INVALID = 3'd7;

    localparam fault_t F_NONE     = 3'd0;
    localparam fault_t F_LAMP     = 3'd1;
    localparam fault_t F_CONFLICT = 3'd2;
    localparam fault_t F_SEQ      = 3'd3;
    localparam fault_t F_STUCK    = 3'd4;

    localparam int LAMP_RED    = 2;
    localparam int LAMP_YELLOW = 1;
    localparam int LAMP_GREEN  = 0;

    function automatic logic one_hot(input logic [2:0] l);
        return l == 3'b001 || l == 3'b010 || l == 3'b100;
    endfunction

    // lane-1 lamps select the first letter; combinations outside the code list are INVALID
    function automatic state_t decode_state(input logic [2:0] l1, input logic [2:0] l2);
        return !(one_hot(l1) && one_hot(l2)) ? ST_INVALID :
               l1[LAMP_RED]   ? (l2[LAMP_RED] ? ST_RR : l2[LAMP_GREEN] ? ST_RG : ST_RY) :
               l1[LAMP_GREEN] ? (l2[LAMP_GREEN] ? ST_GG : l2[LAMP_RED] ? ST_GR : ST_INVALID) :
                                (l2[LAMP_YELLOW] ? ST_YY : l2[LAMP_RED] ? ST_YR : ST_INVALID);
    endfunction

    function automatic state_t next_auto(input state_t s);
        return s == ST_RG ? ST_RY :
               s == ST_RY ? ST_GR :
               s == ST_GR ? ST_YR :
               s == ST_YR ? ST_RG : ST_INVALID;
    endfunction
endpackage

// File: rtl/tl_glitch_filter.sv
// tl_glitch_filter: 2-flop synchronizer on both lamp buses plus a stability
// counter; a new pattern is accepted once held STABLE_CYCLES synchronized cycles.
module tl_glitch_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] raw,
    output logic [5:0] sample,
    output logic [5:0] pattern,
    output logic       accept
);
    logic [5:0] meta, prev;
    logic [3:0] cnt, run;

    // run counts the current cycle too, so acceptance lands STABLE_CYCLES+2 edges after the input edge
    always_comb begin
        run = sample == prev ? cnt + 4'd1 : 4'd1;
        accept = sample != pattern && run == 4'(STABLE_CYCLES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta    <= '0;
            sample  <= '0;
            prev    <= '0;
            pattern <= '0;
            cnt     <= '0;
        end else begin
            meta    <= raw;
            sample  <= meta;
            prev    <= sample;
            pattern <= accept ? sample : pattern;
            cnt     <= (accept || sample == pattern) ? 4'd0 : run;
        end
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive lamp-bus checker recovering state, phase length and sticky faults.
// TLM_DURATION_CHECK_EN enables the STUCK (phase too long) check.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_PHASE     = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_auto,
    input  logic [2:0] led1,
    input  logic [2:0] led2,
    input  logic       clear_fault,
    output logic [2:0] state_dec,
    output logic [6:0] phase_time,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code
);
`ifdef TLM_DURATION_CHECK_EN
    localparam bit DURATION_EN = 1'b1;
`else
    localparam bit DURATION_EN = 1'b0;
`endif

    logic [5:0] sample, pattern;
    logic       accept, mode_q, ref_valid, rise, lamp, conflict, seq, stuck;
    logic [6:0] phase_secs;
    state_t     next_state;
    fault_t     new_fault;

    tl_glitch_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk(clk),
        .reset(reset),
        .raw({led1, led2}),
        .sample(sample),
        .pattern(pattern),
        .accept(accept)
    );

    always_comb begin
        next_state = decode_state(sample[5:3], sample[2:0]);
        state_dec  = decode_state(pattern[5:3], pattern[2:0]);
        rise       = mode_auto && !mode_q;
        lamp       = accept && next_state == ST_INVALID;
        conflict   = accept && mode_auto && next_state == ST_GG;
        // after reset or entering auto, the first accepted pattern only becomes the reference
        seq        = accept && mode_auto && ref_valid && !rise && next_state != next_auto(state_dec);
        stuck      = DURATION_EN && tick && !accept && mode_auto && phase_secs == 7'(MAX_PHASE - 1);
        new_fault  = lamp ? F_LAMP : conflict ? F_CONFLICT : seq ? F_SEQ : stuck ? F_STUCK : F_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= 1'b0;
            ref_valid   <= 1'b0;
            phase_secs  <= '0;
            phase_time  <= '0;
            phase_valid <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= F_NONE;
        end else begin
            mode_q      <= mode_auto;
            ref_valid   <= accept || (ref_valid && !rise);
            phase_valid <= accept;
            if (accept) begin
                phase_time <= phase_secs;
                phase_secs <= '0;
            end else if (tick && phase_secs != 7'd127) begin
                phase_secs <= phase_secs + 7'd1;
            end
            if (clear_fault || !fault) begin
                fault      <= new_fault != F_NONE;
                fault_code <= new_fault;
            end
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: table-driven directed vectors plus hand sequences for
// glitch rejection, duration limit, latency, async reset and clear/fault collision.
module tb_traffic_light_monitor;
    localparam int S = 4;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, BAD = 3'b110;

    logic clk = 1'b0, reset = 1'b1, tick = 1'b0, mode_auto = 1'b0, clear_fault = 1'b0;
    logic [2:0] led1 = '0, led2 = '0;
    logic [2:0] state_dec, fault_code;
    logic [6:0] phase_time;
    logic phase_valid, fault;
    int tests = 0, fails = 0;

    typedef struct {
        logic       clr;
        logic       mode;
        logic [2:0] l1;
        logic [2:0] l2;
        int         ticks;
        logic [2:0] st;
        logic [6:0] pt;
        logic       flt;
        logic [2:0] code;
    } vec_t;
    vec_t tbl[14];

    traffic_light_monitor #(.STABLE_CYCLES(S), .MAX_PHASE(99)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .mode_auto(mode_auto),
        .led1(led1),
        .led2(led2),
        .clear_fault(clear_fault),
        .state_dec(state_dec),
        .phase_time(phase_time),
        .phase_valid(phase_valid),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic m, input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        mode_auto = m;
        led1 = a;
        led2 = b;
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear_fault = 1'b1;
        @(negedge clk) clear_fault = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        led1 = '0;
        led2 = '0;
        mode_auto = 1'b0;
        tick = 1'b0;
        clear_fault = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        int pv_seen;
        //          clr mode l1   l2   ticks st  pt  flt code
        tbl[0]  = '{0, 1, R,   G,  30,   3,  0,  0,  0};
        tbl[1]  = '{0, 1, R,   Y,   3,   4, 30,  0,  0};
        tbl[2]  = '{0, 1, G,   R,  30,   5,  3,  0,  0};
        tbl[3]  = '{0, 1, Y,   R,   3,   6, 30,  0,  0};
        tbl[4]  = '{0, 1, R,   G,   0,   3,  3,  0,  0};
        tbl[5]  = '{0, 1, G,   R,   0,   5,  0,  1,  3};
        tbl[6]  = '{1, 0, R,   G,   0,   3,  0,  0,  0};
        tbl[7]  = '{0, 0, G,   R,   0,   5,  0,  0,  0};
        tbl[8]  = '{0, 1, R,   R,   0,   0,  0,  0,  0};
        tbl[9]  = '{0, 1, R,   G,   0,   3,  0,  1,  3};
        tbl[10] = '{1, 1, BAD, G,   0,   7,  0,  1,  1};
        tbl[11] = '{1, 1, G,   G,   0,   1,  0,  1,  2};
        tbl[12] = '{1, 0, Y,   Y,   0,   2,  0,  0,  0};
        tbl[13] = '{0, 0, BAD, G,   0,   7,  0,  1,  1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 8'(state_dec), 8'd7);
        chk("rst_phase_time", 8'(phase_time), 8'd0);
        chk("rst_phase_valid", 8'(phase_valid), 8'd0);
        chk("rst_fault", 8'(fault), 8'd0);
        chk("rst_code", 8'(fault_code), 8'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].clr) pulse_clear();
            apply(tbl[i].mode, tbl[i].l1, tbl[i].l2);
            step(S + 2);
            chk($sformatf("v%0d_state", i), 8'(state_dec), 8'(tbl[i].st));
            chk($sformatf("v%0d_valid", i), 8'(phase_valid), 8'd1);
            chk($sformatf("v%0d_time", i), 8'(phase_time), 8'(tbl[i].pt));
            chk($sformatf("v%0d_fault", i), 8'(fault), 8'(tbl[i].flt));
            chk($sformatf("v%0d_code", i), 8'(fault_code), 8'(tbl[i].code));
            step(1);
            chk($sformatf("v%0d_valid_off", i), 8'(phase_valid), 8'd0);
            do_ticks(tbl[i].ticks);
        end

        // 3-cycle GG glitch inside an RG phase
        reset_dut();
        apply(1'b1, R, G);
        step(S + 2);
        chk("glitch_pre_state", 8'(state_dec), 8'd3);
        apply(1'b1, G, G);
        repeat (3) @(negedge clk);
        led1 = R;
        led2 = G;
        pv_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            pv_seen += int'(phase_valid);
        end
        chk("glitch_valid_count", 8'(pv_seen), 8'd0);
        chk("glitch_state", 8'(state_dec), 8'd3);
        chk("glitch_fault", 8'(fault), 8'd0);

        // RG held 99 ticks in auto, then latency of the following change
        reset_dut();
        apply(1'b1, R, G);
        step(S + 2);
        chk("stuck_start_state", 8'(state_dec), 8'd3);
        do_ticks(98);
        chk("stuck_98_fault", 8'(fault), 8'd0);
        do_ticks(1);
`ifdef TLM_DURATION_CHECK_EN
        chk("stuck_99_fault", 8'(fault), 8'd1);
        chk("stuck_99_code", 8'(fault_code), 8'd4);
`else
        chk("stuck_99_fault", 8'(fault), 8'd0);
        chk("stuck_99_code", 8'(fault_code), 8'd0);
`endif
        apply(1'b1, R, Y);
        step(S + 1);
        chk("latency_early_state", 8'(state_dec), 8'd3);
        chk("latency_early_valid", 8'(phase_valid), 8'd0);
        step(1);
        chk("latency_state", 8'(state_dec), 8'd4);
        chk("latency_valid", 8'(phase_valid), 8'd1);
        chk("stuck_phase_time", 8'(phase_time), 8'd99);

        // asynchronous reset in the middle of a phase
        do_ticks(5);
        #3 reset = 1'b1;
        #1;
        chk("midrst_state", 8'(state_dec), 8'd7);
        chk("midrst_phase_time", 8'(phase_time), 8'd0);
        chk("midrst_valid", 8'(phase_valid), 8'd0);
        chk("midrst_fault", 8'(fault), 8'd0);
        chk("midrst_code", 8'(fault_code), 8'd0);
        reset_dut();

        // clear_fault in the same cycle a GG is accepted in auto
        apply(1'b1, BAD, G);
        step(S + 2);
        chk("clr_pre_fault", 8'(fault), 8'd1);
        chk("clr_pre_code", 8'(fault_code), 8'd1);
        apply(1'b1, G, G);
        step(S + 1);
        @(negedge clk) clear_fault = 1'b1;
        step(1);
        chk("clr_gg_state", 8'(state_dec), 8'd1);
        chk("clr_gg_fault", 8'(fault), 8'd1);
        chk("clr_gg_code", 8'(fault_code), 8'd2);
        @(negedge clk) clear_fault = 1'b0;
        pulse_clear();
        chk("clr_done_fault", 8'(fault), 8'd0);
        chk("clr_done_code", 8'(fault_code), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
